// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer for the MIPS core.
// Owns the PC, drives a combinational instruction memory, buffers fetched
// words in a 2-entry queue and presents them to decode over valid/ready.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   Start, Halt          leave IDLE (pulse) / suspend fetching (level)
//   ImemAddr, ImemData   instruction memory address (== PC) and returned word
//   Redirect, RedirectPC branch/jump taken pulse and its target
//   IdValid, IdReady     decode handshake; IdInstr/IdPC carry the queue head
//   AddrErr              sticky flag for a misaligned redirect target
//   State                FSM state for debug (IDLE=0, RUN=1, HALTED=2)
//   FetchCount           handshake counter, present only with FETCH_PERF_EN
//
// Optional feature macro: FETCH_PERF_EN

// fifo: generic first-word-fall-through queue with synchronous flush.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: push_rdy drops when full unless the head is popped this cycle.
module fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    // A full queue can still take a word when its head leaves this cycle.
    assign push_rdy = (count != FULL) | (pop_vld & pop_rdy);
    // Flush wins over everything, including a same-cycle pop.
    assign pop      = pop_vld & pop_rdy & ~flush;
    assign push     = push_vld & push_rdy & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// fetch_controller: PC sequencing, start/halt FSM and redirect handling.
// Latency: a word fetched in cycle N is presented to decode in cycle N+1.
// Backpressure: fetch stalls while the queue is full and decode is not ready.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic        Halt,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        IdValid,
    input  logic        IdReady,
    output logic [31:0] IdInstr,
    output logic [31:0] IdPC,
    output logic        AddrErr,
    output logic [1:0]  State
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount
`endif
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

    state_t     state;
    state_t     state_nxt;
    logic [31:0] pc;
    logic        fetch_vld;
    logic        fetch_rdy;
    logic        fetch;
    fetch_ent_t  push_dat;
    fetch_ent_t  head_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Start in IDLE always lands in RUN first, even with Halt high; the
    // HALTED transition follows a cycle later, so no fetch happens in IDLE.
    always_comb begin
        state_nxt = state;
        fetch_vld = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_nxt = RUN;
            end
            RUN: begin
                if (Halt) state_nxt = HALTED;
                fetch_vld = ~Halt & ~Redirect;
            end
            HALTED: begin
                if (!Halt) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fetch = fetch_vld & fetch_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            AddrErr <= 1'b0;
        end else if (Redirect) begin
            pc <= {RedirectPC[31:2], 2'b00};
            if (RedirectPC[1:0] != 2'b00) AddrErr <= 1'b1;
        end else if (fetch) begin
            pc <= pc + 32'd4;
        end
    end

    assign push_dat.pc    = pc;
    assign push_dat.instr = ImemData;

    fifo #(
        .WIDTH ($bits(fetch_ent_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (Redirect),
        .push_vld (fetch_vld),
        .push_rdy (fetch_rdy),
        .push_dat (push_dat),
        .pop_vld  (IdValid),
        .pop_rdy  (IdReady),
        .pop_dat  (head_dat)
    );

    assign ImemAddr = pc;
    assign IdInstr  = head_dat.instr;
    assign IdPC     = head_dat.pc;
    assign State    = state;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FetchCount <= 32'd0;
        end else if (IdValid && IdReady) begin
            FetchCount <= FetchCount + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: self-checking bench for fetch_controller.
// Latency: inputs change 1 time unit after a rising edge, outputs sampled on the falling edge.
// Backpressure: IdReady is driven per scenario to exercise stall and drain.
module tb_fetch_controller;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start;
    logic        Halt;
    logic [31:0] ImemAddr;
    logic [31:0] ImemData;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        IdValid;
    logic        IdReady;
    logic [31:0] IdInstr;
    logic [31:0] IdPC;
    logic        AddrErr;
    logic [1:0]  State;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb [$];
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    // Memory word is the address scrambled so IdInstr and IdPC differ.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    assign ImemData = mem_word(ImemAddr);

    fetch_controller #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Start      (Start),
        .Halt       (Halt),
        .ImemAddr   (ImemAddr),
        .ImemData   (ImemData),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .IdValid    (IdValid),
        .IdReady    (IdReady),
        .IdInstr    (IdInstr),
        .IdPC       (IdPC),
        .AddrErr    (AddrErr),
        .State      (State)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount (FetchCount)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, pulse Start; returns in the first RUN cycle.
    task automatic restart();
        rst_n = 1'b0; Start = 1'b0; Halt = 1'b0; Redirect = 1'b0;
        RedirectPC = 32'd0; IdReady = 1'b0;
        sb.delete();
        step();
        rst_n = 1'b1;
        step();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Start = 1'b0; Halt = 1'b0; Redirect = 1'b0;
        RedirectPC = 32'd0; IdReady = 1'b0;
        step();
        n_cmp++; if (ImemAddr !== 32'd0) begin n_err++; $display("FAIL reset_addr: got %h want 00000000", ImemAddr); end
        n_cmp++; if (IdValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", IdValid); end
        n_cmp++; if (IdInstr !== 32'd0 || IdPC !== 32'd0) begin n_err++; $display("FAIL reset_head: instr %h pc %h want 0 0", IdInstr, IdPC); end
        n_cmp++; if (AddrErr !== 1'b0 || State !== 2'd0) begin n_err++; $display("FAIL reset_flags: err %b state %0d want 0 0", AddrErr, State); end
        rst_n = 1'b1;
        step();
        Redirect = 1'b1; RedirectPC = 32'h0000_0040;
        step();
        Redirect = 1'b0;
        @(negedge clk);
        n_cmp++; if (ImemAddr !== 32'h40 || State !== 2'd0 || IdValid !== 1'b0) begin
            n_err++; $display("FAIL idle_redirect: addr %h state %0d valid %b want 00000040 0 0", ImemAddr, State, IdValid);
        end
    endtask

    task automatic test_stream();
        logic [31:0] model = 32'd0;
        restart();
        IdReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++; if (ImemAddr !== model) begin n_err++; $display("FAIL stream_addr: got %h want %h", ImemAddr, model); end
            n_cmp++; if (IdValid !== (i != 0)) begin n_err++; $display("FAIL stream_valid: cycle %0d got %b want %b", i, IdValid, (i != 0)); end
            sb.push_back(model);
            model += 32'd4;
            if (IdValid && IdReady) begin
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL stream_pop: unexpected IdPC %h", IdPC); end
                else begin
                    exp_pc = sb.pop_front();
                    if (IdPC !== exp_pc || IdInstr !== mem_word(exp_pc)) begin
                        n_err++; $display("FAIL stream_pop: pc %h instr %h want %h %h", IdPC, IdInstr, exp_pc, mem_word(exp_pc));
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic [31:0] model = 32'd8;
        restart();
        @(negedge clk);
        n_cmp++; if (ImemAddr !== 32'd0) begin n_err++; $display("FAIL stall_addr0: got %h want 00000000", ImemAddr); end
        sb.push_back(32'd0);
        step();
        @(negedge clk);
        n_cmp++; if (ImemAddr !== 32'd4 || IdValid !== 1'b1 || IdPC !== 32'd0) begin
            n_err++; $display("FAIL stall_first: addr %h valid %b pc %h want 00000004 1 00000000", ImemAddr, IdValid, IdPC);
        end
        sb.push_back(32'd4);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (ImemAddr !== 32'd8 || IdPC !== 32'd0 || IdInstr !== mem_word(32'd0)) begin
                n_err++; $display("FAIL stall_hold: addr %h pc %h instr %h want 00000008 00000000 %h", ImemAddr, IdPC, IdInstr, mem_word(32'd0));
            end
            step();
        end
        IdReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (ImemAddr !== model || IdValid !== 1'b1) begin
                n_err++; $display("FAIL stall_resume: addr %h valid %b want %h 1", ImemAddr, IdValid, model);
            end
            sb.push_back(model);
            model += 32'd4;
            if (IdValid && IdReady) begin
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL stall_pop: unexpected IdPC %h", IdPC); end
                else begin
                    exp_pc = sb.pop_front();
                    if (IdPC !== exp_pc || IdInstr !== mem_word(exp_pc)) begin
                        n_err++; $display("FAIL stall_pop: pc %h instr %h want %h %h", IdPC, IdInstr, exp_pc, mem_word(exp_pc));
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_redirect();
        logic [31:0] model = 32'h100;
        restart();
        step();
        step();
        Redirect = 1'b1; RedirectPC = 32'h0000_0100;
        @(negedge clk);
        n_cmp++; if (ImemAddr !== 32'd8) begin n_err++; $display("FAIL redir_full: addr %h want 00000008", ImemAddr); end
        step();
        Redirect = 1'b0; IdReady = 1'b1;
        sb.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (IdValid !== (i != 0) || ImemAddr !== model) begin
                n_err++; $display("FAIL redir_seq: cycle %0d valid %b addr %h want %b %h", i, IdValid, ImemAddr, (i != 0), model);
            end
            sb.push_back(model);
            model += 32'd4;
            if (IdValid && IdReady) begin
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL redir_pop: unexpected IdPC %h", IdPC); end
                else begin
                    exp_pc = sb.pop_front();
                    if (IdPC !== exp_pc || IdInstr !== mem_word(exp_pc)) begin
                        n_err++; $display("FAIL redir_pop: pc %h instr %h want %h %h", IdPC, IdInstr, exp_pc, mem_word(exp_pc));
                    end
                end
            end
            step();
        end
        n_cmp++; if (AddrErr !== 1'b0) begin n_err++; $display("FAIL redir_err: got %b want 0", AddrErr); end
    endtask

    task automatic test_misaligned();
        restart();
        Redirect = 1'b1; RedirectPC = 32'h0000_0203;
        step();
        Redirect = 1'b0;
        @(negedge clk);
        n_cmp++; if (ImemAddr !== 32'h200 || AddrErr !== 1'b1) begin
            n_err++; $display("FAIL misalign_set: addr %h err %b want 00000200 1", ImemAddr, AddrErr);
        end
        step();
        Redirect = 1'b1; RedirectPC = 32'h0000_0300;
        step();
        Redirect = 1'b0;
        @(negedge clk);
        n_cmp++; if (ImemAddr !== 32'h300 || AddrErr !== 1'b1) begin
            n_err++; $display("FAIL misalign_sticky: addr %h err %b want 00000300 1", ImemAddr, AddrErr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (AddrErr !== 1'b0) begin n_err++; $display("FAIL misalign_clear: err %b want 0", AddrErr); end
    endtask

    task automatic test_halt();
        restart();
        sb.push_back(32'd0);
        step();
        sb.push_back(32'd4);
        step();
        Halt = 1'b1; IdReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (ImemAddr !== 32'd8) begin n_err++; $display("FAIL halt_pc: cycle %0d addr %h want 00000008", i, ImemAddr); end
            if (i >= 2) begin
                n_cmp++; if (IdValid !== 1'b0 || State !== 2'd2) begin
                    n_err++; $display("FAIL halt_idle: valid %b state %0d want 0 2", IdValid, State);
                end
            end
            if (IdValid && IdReady) begin
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL halt_pop: unexpected IdPC %h", IdPC); end
                else begin
                    exp_pc = sb.pop_front();
                    if (IdPC !== exp_pc || IdInstr !== mem_word(exp_pc)) begin
                        n_err++; $display("FAIL halt_pop: pc %h instr %h want %h %h", IdPC, IdInstr, exp_pc, mem_word(exp_pc));
                    end
                end
            end
            step();
        end
        Halt = 1'b0;
        step();
        @(negedge clk);
        n_cmp++; if (State !== 2'd1 || ImemAddr !== 32'd8) begin
            n_err++; $display("FAIL halt_resume: state %0d addr %h want 1 00000008", State, ImemAddr);
        end
        sb.push_back(32'd8);
        step();
        @(negedge clk);
        n_cmp++; if (ImemAddr !== 32'd12) begin n_err++; $display("FAIL halt_next: addr %h want 0000000c", ImemAddr); end
        if (IdValid && IdReady) begin
            exp_pc = sb.pop_front();
            n_cmp++; if (IdPC !== exp_pc) begin n_err++; $display("FAIL halt_first: pc %h want %h", IdPC, exp_pc); end
        end else begin
            n_cmp++; n_err++; $display("FAIL halt_first: valid %b want 1", IdValid);
        end
    endtask

    task automatic test_start_halt();
        rst_n = 1'b0; Redirect = 1'b0; IdReady = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        Start = 1'b1; Halt = 1'b1;
        step();
        Start = 1'b0;
        @(negedge clk);
        n_cmp++; if (State !== 2'd1 || ImemAddr !== 32'd0) begin
            n_err++; $display("FAIL sh_run: state %0d addr %h want 1 00000000", State, ImemAddr);
        end
        step();
        @(negedge clk);
        n_cmp++; if (State !== 2'd2 || ImemAddr !== 32'd0 || IdValid !== 1'b0) begin
            n_err++; $display("FAIL sh_halted: state %0d addr %h valid %b want 2 00000000 0", State, ImemAddr, IdValid);
        end
        Halt = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] model = 32'hFFFF_FFF8;
        restart();
        IdReady = 1'b1;
        Redirect = 1'b1; RedirectPC = 32'hFFFF_FFF8;
        step();
        Redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (ImemAddr !== model || IdValid !== (i != 0)) begin
                n_err++; $display("FAIL wrap_seq: addr %h valid %b want %h %b", ImemAddr, IdValid, model, (i != 0));
            end
            sb.push_back(model);
            model += 32'd4;
            if (IdValid && IdReady) begin
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL wrap_pop: unexpected IdPC %h", IdPC); end
                else begin
                    exp_pc = sb.pop_front();
                    if (IdPC !== exp_pc || IdInstr !== mem_word(exp_pc)) begin
                        n_err++; $display("FAIL wrap_pop: pc %h instr %h want %h %h", IdPC, IdInstr, exp_pc, mem_word(exp_pc));
                    end
                end
            end
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (IdValid !== 1'b0 || ImemAddr !== 32'd0 || State !== 2'd0) begin
            n_err++; $display("FAIL async_reset: valid %b addr %h state %0d want 0 00000000 0", IdValid, ImemAddr, State);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_halt();
        test_start_halt();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
